uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART RX control FSM and deserializer.
- Captures each completed frame's parallel byte once per Data_Valid assertion and stores it with its parity-error flag.
- Presents the stored bytes to the host through a show-ahead valid/ready read port.
- Counts frames lost to overflow so that a slow consumer never silently corrupts the stream.

Parameters:
- DATA_WIDTH, 8, width of P_DATA and rd_data.
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- ADDR_WIDTH, 3, log2(DEPTH).
- DROP_CNT_WIDTH, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- P_DATA  in  DATA_WIDTH  deserialized frame byte; stable while Data_Valid is high.
- Data_Valid  in  1  frame-good level from the RX FSM; may stay high for many clk cycles per frame.
- parity_err  in  1  parity result for the current frame; sampled together with P_DATA.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  DATA_WIDTH  byte at the head of the FIFO.
- rd_par_err  out  1  parity flag stored with the head entry.
- rd_valid  out  1  head entry is valid (FIFO not empty).
- full  out  1  count == DEPTH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag; set when a frame is dropped.
- ovf_clr  in  1  clears overflow and drop_cnt.
- drop_cnt  out  DROP_CNT_WIDTH  number of dropped frames; saturates at all-ones.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr, rd_ptr, count, dv_q, overflow and drop_cnt go to 0.
  - rd_valid=0, full=0.
  - Memory contents are not reset; rd_data/rd_par_err are don't-care while rd_valid=0.
  - Reset overrides every other input in the same cycle, including mid-frame Data_Valid and pending reads.
- Edge detect:
  - dv_q <= Data_Valid every cycle.
  - wr_req = Data_Valid & ~dv_q, giving exactly one write request per Data_Valid high period regardless of its length.
  - If Data_Valid is already high on the first cycle after reset, dv_q=0, so one write occurs.
- Write:
  - When wr_req & ~full_eff: mem[wr_ptr] <= {parity_err, P_DATA}; wr_ptr increments modulo DEPTH.
  - full_eff = full & ~rd_fire.
- Read:
  - rd_fire = rd_valid & rd_ready.
  - rd_data and rd_par_err show-ahead from mem[rd_ptr]; combinational read of registered storage, zero-latency head.
  - On rd_fire, rd_ptr increments modulo DEPTH.
  - rd_ready while empty has no effect.
- Occupancy:
  - count increments on write only, decrements on read only, and is unchanged when both occur.
  - rd_valid = (count != 0); full = (count == DEPTH).
  - Pointers use ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
- Simultaneous read and write:
  - When full: the write is accepted, with no overflow and count staying at DEPTH.
  - When count==1: the new entry becomes head next cycle and rd_valid stays 1.
  - When empty: only the write occurs. There is no bypass; data is visible the cycle after the write.
- Overflow:
  - On wr_req & full & ~rd_fire, the frame is discarded and memory and pointers are unchanged.
  - overflow <= 1 and drop_cnt <= drop_cnt+1, saturating at 2^DROP_CNT_WIDTH-1.
  - ovf_clr clears overflow and drop_cnt to 0 on the next edge.
  - If ovf_clr coincides with a drop, the drop wins: overflow=1, drop_cnt=1.
- Latency:
  - Data_Valid rising at edge N (seen by dv_q=0) writes at edge N+1.
  - rd_valid is high after edge N+1.
- No state machine beyond the pointer/count registers; all outputs are registered or derived from registered state.

Test Plan:
- Reset, then Data_Valid high for 1 cycle with P_DATA=8'hA5, parity_err=0 -> one cycle later rd_valid=1, rd_data=A5, rd_par_err=0, count=1; rd_ready=1 for one cycle -> rd_valid=0, count=0.
- Data_Valid held high for 16 cycles with P_DATA=8'h3C -> exactly one entry written, count=1.
- Write 8 frames 00..07 with rd_ready=0 -> full=1, count=8. Ninth frame 8'hFF -> overflow=1, drop_cnt=1, count=8. Drain -> reads 00..07 in order and FF is never seen. Pulse ovf_clr -> overflow=0, drop_cnt=0.
- Full FIFO, rd_ready=1 on the same cycle as a new frame 8'h55 -> no overflow, count stays 8. Subsequent drain -> 01..07 then 55.
- Write 20 frames interleaved with reads, keeping count ≤3, with parity_err=1 on every third frame -> pointer wrap is correct, all 20 bytes arrive in order, and the rd_par_err pattern matches.
- rst asserted while count=5 and Data_Valid rising in the same cycle -> next cycle count=0, rd_valid=0, no write. Data_Valid still high afterwards -> one write.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO between the UART RX deserializer and the host
//
// Captures one byte per Data_Valid high period, together with its parity flag.
// The host reads the bytes through a show-ahead valid/ready port.
// Frames that arrive while the FIFO is full are discarded and counted.
//
// Ports:
//   clk         single clock
//   rst         synchronous active-high reset
//   P_DATA      deserialized frame byte, stable while Data_Valid is high
//   Data_Valid  frame-good level from the RX FSM, may stay high for many cycles
//   parity_err  parity result for the current frame
//   rd_ready    consumer accepts the head entry this cycle
//   rd_data     head entry byte (show-ahead)
//   rd_par_err  head entry parity flag
//   rd_valid    FIFO not empty
//   full        occupancy equals DEPTH
//   count       occupancy, 0..DEPTH
//   overflow    sticky, set when a frame is dropped
//   ovf_clr     clears overflow and drop_cnt
//   drop_cnt    saturating count of dropped frames

module uart_rx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      parity_err,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_par_err,
    output logic                      rd_valid,
    output logic                      full,
    output logic [ADDR_WIDTH:0]       count,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Each entry holds {parity_err, byte}.
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  dv_q;

    logic wr_req;
    logic rd_fire;
    logic full_eff;
    logic wr_en;
    logic drop;

    // Data_Valid is a level that can last many cycles; only its rising edge
    // represents a new frame.
    assign wr_req   = Data_Valid & ~dv_q;

    assign rd_valid = (count != '0);
    assign full     = (count == FULL_COUNT);
    assign rd_fire  = rd_valid & rd_ready;

    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign full_eff = full & ~rd_fire;
    assign wr_en    = wr_req & ~full_eff;
    assign drop     = wr_req & full_eff;

    // Show-ahead head: combinational read of registered storage.
    assign {rd_par_err, rd_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= Data_Valid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (wr_en && !rd_fire) begin
                count <= count + (ADDR_WIDTH + 1)'(1);
            end else if (rd_fire && !wr_en) begin
                count <= count - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    // Storage is not reset; reset only blocks a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= {parity_err, P_DATA};
        end
    end

    // A drop that coincides with ovf_clr is kept: the clear applies to the
    // history before this edge, and the new loss restarts the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= DROP_CNT_WIDTH'(1);
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule
